fetch_queue_if: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/fetch_queue_if.sv | 109 ++++++++++
 tb/tb_fetch_queue_if.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the queued instruction-fetch stage.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int PC_INCR = 4;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; push into a full FIFO is accepted only with a same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; entries are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge CLK) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (!reset_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue_if.sv
// Fetch stage: PC generation, credit-limited requests to a variable-latency imem,
// and an in-order instruction queue feeding decode; redirects flush and drop in-flight responses.
module fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            PCSrcD,
    input  logic [XLEN-1:0] PCBranchD,
    input  logic            StallF,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            ValidF,
    output logic [XLEN-1:0] InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F
);

    localparam int              CW      = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] INCR    = XLEN'(PC_INCR);
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   tail_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_next;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     drop_next;
    logic [CW-1:0]     q_count;
    logic [CW:0]       credits_used;
    logic              req_fire;
    logic              resp_keep;
    logic              q_pop;
    logic              q_empty;
    logic              q_full;
    logic [2*XLEN-1:0] q_head;

    // Every buffered or in-flight instruction holds one credit, so a response always finds room.
    assign credits_used   = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req_valid = reset_n && !PCSrcD && (credits_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && (drop == '0) && !PCSrcD;

    assign ValidF         = reset_n && !q_empty;
    assign q_pop          = ValidF && !StallF && !PCSrcD;
    assign {PCF, InstrF}  = q_head;
    assign PCPlus4F       = PCF + INCR;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);
        drop_next        = drop;
        if (PCSrcD)
            drop_next = outstanding_next;
        else if (imem_resp_valid && (drop != '0))
            drop_next = drop - CW'(1);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            tail_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop        <= drop_next;
            if (PCSrcD) begin
                fetch_pc <= PCBranchD;
                tail_pc  <= PCBranchD;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + INCR;
                if (resp_keep)
                    tail_pc <= tail_pc + INCR;
            end
        end
    end

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .CLK     (CLK),
        .reset_n (reset_n),
        .flush   (PCSrcD),
        .push    (resp_keep),
        .pop     (q_pop),
        .wdata   ({tail_pc, imem_resp_data}),
        .rdata   (q_head),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    // A kept response arriving at a full queue without a pop means the credit rule was broken.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!reset_n)
        !(resp_keep && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_queue_if.sv
// Self-checking bench: behavioural imem with latency/backpressure and an epoch-tagged scoreboard.
module tb_fetch_queue_if;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        StallF;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;

    always #5 CLK = ~CLK;

    fetch_queue_if #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .CLK             (CLK),
        .reset_n         (reset_n),
        .PCSrcD          (PCSrcD),
        .PCBranchD       (PCBranchD),
        .StallF          (StallF),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ValidF          (ValidF),
        .InstrF          (InstrF),
        .PCF             (PCF),
        .PCPlus4F        (PCPlus4F)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          q_model = 0;
    int          lat = 1;
    int          p_ready = 100;
    int          p_stall = 0;
    int          p_redir = 0;
    logic [31:0] exp_pc = RST_PC;
    bit          rst_req = 1'b0;
    bit          redir_req = 1'b0;
    logic [31:0] redir_tgt = '0;
    bit          resp_cur = 1'b0;
    int          resp_epoch = 0;
    bit          drop_chk = 1'b0;
    int          drop_exp = 0;
    bit          track = 1'b0;
    int          first_hs = -1;
    int          first_vf = -1;
    bit          found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs for the coming cycle, applied just after the rising edge.
    task automatic drive();
        cyc++;
        reset_n        = !rst_req;
        PCSrcD         = redir_req;
        PCBranchD      = redir_tgt;
        redir_req      = 1'b0;
        if (!rst_req && ($urandom_range(999) < p_redir)) begin
            PCSrcD    = 1'b1;
            PCBranchD = $urandom() & 32'hFFFF_FFFC;
        end
        imem_req_ready  = ($urandom_range(99) < p_ready);
        StallF          = ($urandom_range(99) < p_stall);
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        resp_cur        = 1'b0;
        if (!rst_req && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
            resp_epoch      = mem_q[0].epoch;
            resp_cur        = 1'b1;
            void'(mem_q.pop_front());
        end
    endtask

    // Compares outputs at the falling edge, then advances the model to what the next edge commits.
    task automatic sample();
        int used;
        if (drop_chk) begin
            check("drop_after_redirect", 32'(dut.drop), drop_exp);
            drop_chk = 1'b0;
        end
        if (!reset_n) begin
            check("reset_req_valid", 32'(imem_req_valid), 0);
            check("reset_ValidF", 32'(ValidF), 0);
            mem_q.delete();
            exp_q.delete();
            q_model = 0;
            exp_pc  = RST_PC;
            epoch++;
            return;
        end
        used = mem_q.size() + (resp_cur ? 1 : 0) + q_model;
        check("ValidF", 32'(ValidF), 32'(q_model > 0));
        check("req_valid", 32'(imem_req_valid), 32'(!PCSrcD && used < DEPTH));
        if (track && ValidF && first_vf < 0) begin
            first_vf = cyc;
            check("first_PCF", PCF, RST_PC);
            check("first_PCPlus4F", PCPlus4F, RST_PC + 32'd4);
        end
        if (ValidF && q_model > 0 && !StallF && !PCSrcD) begin
            check("PCF", PCF, exp_q[0].pc);
            check("InstrF", InstrF, exp_q[0].instr);
            check("PCPlus4F", PCPlus4F, exp_q[0].pc + 32'd4);
            void'(exp_q.pop_front());
            q_model--;
        end
        if (resp_cur && resp_epoch == epoch && !PCSrcD)
            q_model++;
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + lat, epoch: epoch});
            exp_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
            exp_pc += 32'd4;
            if (track && first_hs < 0)
                first_hs = cyc;
        end
        if (PCSrcD) begin
            epoch++;
            exp_q.delete();
            q_model  = 0;
            exp_pc   = PCBranchD;
            drop_exp = mem_q.size();
            drop_chk = 1'b1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            drive();
            @(negedge CLK);
            sample();
        end
    endtask

    task automatic do_reset(input int n);
        rst_req = 1'b1;
        run(n);
        rst_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; PCSrcD = 1'b0; PCBranchD = '0; StallF = 1'b0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        do_reset(3);

        // 1-cycle memory, free-running decode
        lat = 1; p_ready = 100; p_stall = 0; track = 1'b1;
        run(12);
        track = 1'b0;
        check("first_valid_latency", 32'(first_vf - first_hs), 32'd2);

        // redirect coincident with a response and a dequeue
        redir_req = 1'b1; redir_tgt = 32'h100;
        run(1);
        run(8);

        // decode stalled: queue fills, issue stops, head holds
        do_reset(2);
        p_stall = 100;
        run(10);
        check("stall_count", 32'(dut.q_count), 32'd4);
        check("stall_head_pc", PCF, RST_PC);
        check("stall_req_valid", 32'(imem_req_valid), 32'd0);
        p_stall = 0;
        run(10);

        // 3-cycle memory with requests in flight, then redirect
        do_reset(2);
        lat = 3;
        run(3);
        redir_req = 1'b1; redir_tgt = 32'h100;
        run(1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            run(1);
            if (ValidF) begin
                found = 1'b1;
                check("redirect_first_pc", PCF, 32'h100);
            end
        end
        check("redirect_first_seen", 32'(found), 32'd1);

        // random backpressure, stalls and occasional redirects
        lat = 2; p_ready = 60; p_stall = 30; p_redir = 10;
        run(10000);
        p_redir = 0;

        // reset mid-stream with a partly full queue and requests in flight
        p_ready = 100; p_stall = 100;
        run(3);
        do_reset(1);
        p_stall = 0;
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
